// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: shares one slave port between NUM_MASTERS masters,
// holding the grant for a whole cyc and terminating stalled strobes with a watchdog err.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,

  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,

  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,

  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        busy_o
);

  // Handshake: stb (qualified by cyc) is the request valid; ack/err/rty is the
  // single-cycle completion. A beat completes on the edge where stb and a termination
  // are both high; the owner keeps its signals stable until then.

  localparam int  SW     = DW / 8;
  localparam int  LW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int  WDW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit  WD_EN  = (TIMEOUT > 0);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [LW:0]    N_EXT  = (LW+1)'(NUM_MASTERS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [LW-1:0]           last_q;
  logic [WDW-1:0]          wd_cnt;

  logic [NUM_MASTERS-1:0]  win_oh;
  logic [LW-1:0]           win_idx;

  logic [AW-1:0]           mux_adr;
  logic [DW-1:0]           mux_dat;
  logic [SW-1:0]           mux_sel;
  logic                    mux_we;
  logic [2:0]              mux_cti;
  logic [1:0]              mux_bte;
  logic                    cyc_g;
  logic                    stb_g;
  logic                    term;
  logic                    wd_hit;
  logic                    wd_fire;

  // Scan offsets from far to near so the requester closest after last_q is kept.
  always_comb begin
    logic [LW:0]   sum;
    logic [LW-1:0] idx;
    win_oh  = '0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      sum = {1'b0, last_q} + (LW+1)'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      idx = sum[LW-1:0];
      if (m_cyc_i[idx]) begin
        win_oh      = '0;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

  // grant_q is all-zero in IDLE, so every muxed slave signal is 0 there.
  always_comb begin
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    mux_we  = 1'b0;
    mux_cti = '0;
    mux_bte = '0;
    cyc_g   = 1'b0;
    stb_g   = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        mux_adr = m_adr_i[k*AW +: AW];
        mux_dat = m_dat_i[k*DW +: DW];
        mux_sel = m_sel_i[k*SW +: SW];
        mux_we  = m_we_i[k];
        mux_cti = m_cti_i[k*3 +: 3];
        mux_bte = m_bte_i[k*2 +: 2];
        cyc_g   = m_cyc_i[k];
        stb_g   = m_stb_i[k] & m_cyc_i[k];
      end
    end
  end

  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign wd_hit  = WD_EN && (wd_cnt == WD_MAX);
  // Strobe suppression uses only the counter, keeping s_stb_o free of any path from
  // the slave's terminations; a late termination still overrides the watchdog err.
  assign wd_fire = stb_g & wd_hit & ~term;

  assign s_adr_o = mux_adr;
  assign s_dat_o = mux_dat;
  assign s_sel_o = mux_sel;
  assign s_we_o  = mux_we;
  assign s_cti_o = mux_cti;
  assign s_bte_o = mux_bte;
  assign s_cyc_o = cyc_g;
  assign s_stb_o = stb_g & ~wd_hit;

  assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = grant_q & {NUM_MASTERS{s_err_i | wd_fire}};
  assign m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
  assign m_dat_o = (state == BUSY) ? {NUM_MASTERS{s_dat_i}} : '0;

  assign grant_o = grant_q;
  assign busy_o  = (state == BUSY);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|m_cyc_i) begin
            grant_q <= win_oh;
            last_q  <= win_idx;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            state   <= IDLE;
            grant_q <= '0;
            wd_cnt  <= '0;
          end else if (WD_EN && s_stb_o && !term) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          wd_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios followed by randomized
// rounds, all compared against a round-robin reference model kept in the bench.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef logic [1:0] mid_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N*4-1:0]  m_sel_i = '0;
  logic [N-1:0]    m_we_i = '0;
  logic [N-1:0]    m_cyc_i = '0;
  logic [N-1:0]    m_stb_i = '0;
  logic [N*3-1:0]  m_cti_i = '0;
  logic [N*2-1:0]  m_bte_i = '0;
  logic [N*DW-1:0] m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_we_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_cyc_o, s_stb_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, required finish before 1000000");
    $fatal(1);
  end

  // Reference model state: pending requests, last owner, per-master driven values.
  logic [N-1:0]  req = '0;
  mid_t          last_m = 2'd3;
  logic [31:0]   adr_v [N];
  logic [31:0]   dat_v [N];
  logic [3:0]    sel_v [N];
  logic          we_v  [N];
  logic [1:0]    bte_v [N];
  logic [N-1:0]  exp_q [$];
  logic [N-1:0]  last_grant_seen;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Next owner: first requester at last+1, last+2, ... modulo N.
  function automatic mid_t rr_pick(input logic [N-1:0] r, input mid_t last);
    for (int i = 1; i <= N; i++) begin
      mid_t c;
      c = mid_t'(int'(last) + i);
      if (r[c]) return c;
    end
    return last;
  endfunction

  // Driver tasks
  task automatic raise(input mid_t k, input logic [31:0] adr);
    adr_v[k] = adr;
    dat_v[k] = $urandom;
    sel_v[k] = 4'($urandom_range(1, 15));
    we_v[k]  = 1'($urandom_range(0, 1));
    bte_v[k] = 2'($urandom_range(0, 3));
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = dat_v[k];
    m_sel_i[k*4 +: 4]   = sel_v[k];
    m_we_i[k]           = we_v[k];
    m_bte_i[k*2 +: 2]   = bte_v[k];
    m_cti_i[k*3 +: 3]   = 3'b000;
    m_cyc_i[k] = 1'b1;
    m_stb_i[k] = 1'b1;
    req[k]     = 1'b1;
  endtask

  task automatic drop(input mid_t k);
    m_cyc_i[k] = 1'b0;
    m_stb_i[k] = 1'b0;
    req[k]     = 1'b0;
  endtask

  // Entered at a negedge with the arbiter idle and requests already driven.
  task automatic serve(input int beats, input int lat, input int resp,
                       input logic [31:0] rd0, input bit rearm, input int late_k);
    mid_t        w;
    logic [N-1:0] oh;
    logic [31:0] base;
    logic [2:0]  cti;
    logic [31:0] rdat;
    logic [3*N-1:0] exp_term;
    w = rr_pick(req, last_m);
    last_m = w;
    oh = 4'b0001 << w;
    exp_q.push_back(oh);
    base = adr_v[w];
    @(negedge clk); #1;
    last_grant_seen = grant_o;
    check("grant", 32'(grant_o), 32'(exp_q.pop_front()));
    check("busy_on", 32'(busy_o), 32'd1);
    check("s_cyc_on", 32'(s_cyc_o), 32'd1);
    check("s_dat_mux", s_dat_o, dat_v[w]);
    check("s_sel_mux", 32'(s_sel_o), 32'(sel_v[w]));
    check("s_we_mux", 32'(s_we_o), 32'(we_v[w]));
    check("s_bte_mux", 32'(s_bte_o), 32'(bte_v[w]));
    for (int b = 0; b < beats; b++) begin
      cti = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      m_adr_i[w*AW +: AW] = base + 32'(4 * b);
      m_cti_i[w*3 +: 3]   = cti;
      if (b == 1 && late_k >= 0 && !req[mid_t'(late_k)])
        raise(mid_t'(late_k), 32'h0000_5000 + 32'(16 * late_k));
      for (int l = 0; l < lat; l++) begin
        #1;
        check("wait_no_term", 32'({m_ack_o, m_err_o, m_rty_o}), 32'd0);
        check("wait_stb", 32'(s_stb_o), 32'd1);
        @(negedge clk);
      end
      rdat    = rd0 + 32'(b);
      s_dat_i = rdat;
      s_ack_i = (resp == 0);
      s_err_i = (resp == 1);
      s_rty_i = (resp == 2);
      #1;
      exp_term = {(resp == 0) ? oh : 4'b0, (resp == 1) ? oh : 4'b0, (resp == 2) ? oh : 4'b0};
      check("grant_hold", 32'(grant_o), 32'(oh));
      check("s_adr_beat", s_adr_o, base + 32'(4 * b));
      check("s_cti_beat", 32'(s_cti_o), 32'(cti));
      check("term_route", 32'({m_ack_o, m_err_o, m_rty_o}), 32'(exp_term));
      check("m_dat_rd", m_dat_o[w*DW +: DW], rdat);
      @(negedge clk);
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_rty_i = 1'b0;
    end
    drop(w);
    #1;
    check("drop_s_cyc", 32'(s_cyc_o), 32'd0);
    check("drop_s_stb", 32'(s_stb_o), 32'd0);
    check("drop_still_busy", 32'(busy_o), 32'd1);
    @(negedge clk); #1;
    check("idle_grant", 32'(grant_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_m_dat", m_dat_o[31:0], 32'd0);
    check("idle_s_cyc", 32'(s_cyc_o), 32'd0);
    if (rearm) raise(w, $urandom & 32'hFFFF_FFF0);
  endtask

  logic [N-1:0] fair_order [5];

  initial begin
    mid_t        w;
    logic [N-1:0] oh;
    fair_order[0] = 4'b0001; fair_order[1] = 4'b0010; fair_order[2] = 4'b0100;
    fair_order[3] = 4'b1000; fair_order[4] = 4'b0001;

    // Reset held with every master requesting: nothing may be driven.
    #1 rst_n = 1'b0;
    for (int k = 0; k < N; k++) raise(mid_t'(k), 32'h0000_1000 + 32'(k * 16));
    s_dat_i = 32'hA5A5_A5A5;
    s_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_s_stb", 32'(s_stb_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_m_ack", 32'(m_ack_o), 32'd0);
    check("rst_m_dat", m_dat_o[31:0], 32'd0);

    // Single master 1 read at 0x100, slave acks after 2 wait cycles.
    @(negedge clk);
    for (int k = 0; k < N; k++) drop(mid_t'(k));
    s_ack_i = 1'b0;
    raise(2'd1, 32'h0000_0100);
    last_m = 2'd3;
    rst_n  = 1'b1;
    serve(1, 2, 0, 32'hDEAD_BEEF, 1'b0, -1);

    // Burst lock: master 0 4-beat burst, master 2 requests during beat 1.
    raise(2'd0, 32'h0000_2000);
    serve(4, 0, 0, $urandom, 1'b0, 2);
    serve(1, 1, 0, $urandom, 1'b0, -1);

    // Watchdog: master 1 never terminated, master 3 waits behind it.
    raise(2'd1, 32'h0000_3000);
    w = rr_pick(req, last_m);
    last_m = w;
    oh = 4'b0001 << w;
    @(negedge clk); #1;
    check("wd_grant", 32'(grant_o), 32'(oh));
    raise(2'd3, 32'h0000_3100);
    for (int i = 0; i < TO; i++) begin
      check("wd_quiet_err", 32'(m_err_o), 32'd0);
      check("wd_stb_high", 32'(s_stb_o), 32'd1);
      @(negedge clk); #1;
    end
    check("wd_err", 32'(m_err_o), 32'(oh));
    check("wd_stb_forced", 32'(s_stb_o), 32'd0);
    check("wd_grant_kept", 32'(grant_o), 32'(oh));
    @(negedge clk); #1;
    check("wd_err_pulse", 32'(m_err_o), 32'd0);
    drop(w);
    @(negedge clk); #1;
    check("wd_idle", 32'(grant_o), 32'd0);
    serve(1, 1, 0, $urandom, 1'b0, -1);

    // Async reset during beat 2 of a burst.
    raise(2'd0, 32'h0000_4000);
    w = rr_pick(req, last_m);
    last_m = w;
    oh = 4'b0001 << w;
    @(negedge clk); #1;
    check("ar_grant", 32'(grant_o), 32'(oh));
    for (int b = 0; b < 3; b++) begin
      m_adr_i[w*AW +: AW] = adr_v[w] + 32'(4 * b);
      m_cti_i[w*3 +: 3]   = 3'b010;
      s_ack_i = 1'b1;
      #1;
      check("ar_beat_ack", 32'(m_ack_o), 32'(oh));
      if (b < 2) begin
        @(negedge clk);
        s_ack_i = 1'b0;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    check("ar_s_cyc", 32'(s_cyc_o), 32'd0);
    check("ar_s_stb", 32'(s_stb_o), 32'd0);
    check("ar_grant_clr", 32'(grant_o), 32'd0);
    check("ar_busy_clr", 32'(busy_o), 32'd0);
    check("ar_ack_clr", 32'(m_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0;
    drop(w);
    for (int k = 0; k < N; k++) raise(mid_t'(k), 32'h0000_6000 + 32'(k * 64));
    last_m = 2'd3;
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all masters keep requesting, each re-requests after its access.
    for (int i = 0; i < 5; i++) begin
      serve(1, $urandom_range(0, 2), 0, $urandom, 1'b1, -1);
      check("fair_order", 32'(last_grant_seen), 32'(fair_order[i]));
    end

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++)
        if (!req[k] && $urandom_range(0, 2) == 0) raise(mid_t'(k), $urandom & 32'hFFFF_FFF0);
      if (req == '0) raise(mid_t'($urandom_range(0, N - 1)), $urandom & 32'hFFFF_FFF0);
      serve($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom, 1'($urandom_range(0, 1)), -1);
    end

    for (int k = 0; k < N; k++) drop(mid_t'(k));
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
